data_mem_responder: RTL and testbench

- Responder (slave) end of the microcontroller's data-memory bus: accepts load/store requests from the core over a req/ack handshake and serves them from an internal RAM.
- Inserts a programmable number of wait states.
- Flags out-of-range addresses instead of aliasing.
- Sits beside the program memory inside the microcontroller top and is the counterpart of the core's load/store initiator logic.

---
 rtl/mcu_bus_pkg.sv | 19 +
 rtl/sp_ram.sv | 27 ++
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 tb/tb_data_mem_responder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mcu_bus_pkg.sv
// Shared data-memory bus definitions: responder FSM encoding and default bus widths
// common to the core's load/store unit and the data-memory responder.
package mcu_bus_pkg;

   localparam int BUS_ADDR_W = 8;
   localparam int BUS_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } bus_state_t;

   // A one-entry memory still needs a one-bit index.
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM, DEPTH x DATA_W, registered read (read-before-write).
module sp_ram #(
   parameter int DEPTH  = 256,
   parameter int DATA_W = 8,
   parameter int IDX_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];
   logic [DATA_W-1:0] r_rdata;

   // Storage is deliberately not reset.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory bus responder: captures a load/store on Req, inserts WAIT_CYCLES wait
// states, then pulses Ack with Err for addresses >= DEPTH.
module data_mem_responder
   import mcu_bus_pkg::*;
#(
   parameter int ADDR_W      = BUS_ADDR_W,
   parameter int DATA_W      = BUS_DATA_W,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_ack,
   output logic              o_err,
   output logic              o_busy
);

   localparam int IDX_W = idx_width(DEPTH);

   bus_state_t        r_state, w_state_nxt;
   logic [3:0]        r_cnt, w_cnt_nxt;
   logic              r_we, w_we_nxt;
   logic [ADDR_W-1:0] r_addr, w_addr_nxt;
   logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
   logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
   logic              r_ack, w_ack_nxt;
   logic              r_err, w_err_nxt;
   logic              r_busy, w_busy_nxt;

   logic [ADDR_W-1:0] w_sel_addr;
   logic              w_sel_ok;
   logic              w_cap_ok;
   logic [IDX_W-1:0]  w_ram_idx;
   logic              w_ram_we;
   logic [DATA_W-1:0] w_ram_q;

   // The RAM is read every cycle; in IDLE it follows the live bus so a zero-wait load
   // has its data ready when RESP completes. Out-of-range addresses never index the RAM.
   assign w_sel_addr = (r_state == ST_IDLE) ? i_addr : r_addr;
   assign w_sel_ok   = (64'(w_sel_addr) < 64'(DEPTH));
   assign w_cap_ok   = (64'(r_addr) < 64'(DEPTH));
   assign w_ram_idx  = w_sel_ok ? w_sel_addr[IDX_W-1:0] : {IDX_W{1'b0}};
   assign w_ram_we   = (r_state == ST_RESP) && r_we && w_cap_ok && !i_rst;

   sp_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_idx),
      .i_wdata (r_wdata),
      .o_rdata (w_ram_q)
   );

   // Next-state and registered-output logic; RESP is the cycle before the Ack pulse.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_we_nxt    = r_we;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_rdata_nxt = r_rdata;
      w_ack_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
      w_busy_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_req) begin
               w_we_nxt    = i_we;
               w_addr_nxt  = i_addr;
               w_wdata_nxt = i_wdata;
               w_busy_nxt  = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  w_state_nxt = ST_RESP;
               end else begin
                  w_cnt_nxt   = 4'(WAIT_CYCLES);
                  w_state_nxt = ST_WAIT;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WAIT: begin
            w_busy_nxt = 1'b1;
            if (r_cnt == 4'd1) begin
               w_cnt_nxt   = 4'd0;
               w_state_nxt = ST_RESP;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         ST_RESP: begin
            w_busy_nxt  = 1'b1;
            w_ack_nxt   = 1'b1;
            w_err_nxt   = !w_cap_ok;
            w_state_nxt = ST_IDLE;
            if (!r_we) begin
               w_rdata_nxt = w_cap_ok ? w_ram_q : {DATA_W{1'b0}};
            end else begin
               w_rdata_nxt = r_rdata;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_addr  <= {ADDR_W{1'b0}};
         r_wdata <= {DATA_W{1'b0}};
         r_rdata <= {DATA_W{1'b0}};
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_we    <= w_we_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
         r_rdata <= w_rdata_nxt;
         r_ack   <= w_ack_nxt;
         r_err   <= w_err_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign o_rdata = r_rdata;
   assign o_ack   = r_ack;
   assign o_err   = r_err;
   assign o_busy  = r_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: DEPTH=200 with 2 wait states, plus a
// zero-wait instance for back-to-back transfers.
module tb_data_mem_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, we0, req1, we1;
   logic [7:0] addr0, wd0, rd0, addr1, wd1, rd1;
   logic       ack0, err0, busy0, ack1, err1, busy1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(200), .WAIT_CYCLES(2)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_req(req0), .i_we(we0), .i_addr(addr0),
      .i_wdata(wd0), .o_rdata(rd0), .o_ack(ack0), .o_err(err0), .o_busy(busy0)
   );

   data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(200), .WAIT_CYCLES(0)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_req(req1), .i_we(we1), .i_addr(addr1),
      .i_wdata(wd1), .o_rdata(rd1), .o_ack(ack1), .o_err(err1), .o_busy(busy1)
   );

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wd;
      logic [7:0] exp_rd;
      logic       exp_err;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One transaction on dut0; perturb changes Addr/We/WData right after capture.
   task automatic txn0(input logic we, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input logic exp_err, input logic perturb);
      int n;
      bit got;
      @(negedge clk);
      req0 = 1'b1; we0 = we; addr0 = a; wd0 = d;
      @(posedge clk);
      n = 0;
      got = 1'b0;
      while (!got && n < 12) begin
         @(negedge clk);
         n++;
         if (perturb && n == 1) begin
            addr0 = a + 8'd1; we0 = 1'b1; wd0 = 8'hEE;
         end
         if (ack0 === 1'b1) got = 1'b1;
      end
      req0 = 1'b0;
      check("ack_seen", 32'(got), 32'd1);
      check("ack_latency_edges", 32'(n - 1), 32'd3);
      check("err_at_ack", 32'(err0), 32'(exp_err));
      check("busy_at_ack", 32'(busy0), 32'd1);
      check(we ? "rdata_hold_on_store" : "rdata_load", 32'(rd0), 32'(exp_rd));
      @(negedge clk);
      check("idle_after_ack", {29'd0, ack0, err0, busy0}, 32'd0);
   endtask

   initial begin
      bit ack_any;

      vecs[0]  = '{1'b1, 8'h00, 8'h77, 8'h00, 1'b0};
      vecs[1]  = '{1'b1, 8'h20, 8'h00, 8'h00, 1'b0};
      vecs[2]  = '{1'b1, 8'h10, 8'hA5, 8'h00, 1'b0};
      vecs[3]  = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
      vecs[4]  = '{1'b1, 8'hC8, 8'h55, 8'hA5, 1'b1};
      vecs[5]  = '{1'b0, 8'hC8, 8'h00, 8'h00, 1'b1};
      vecs[6]  = '{1'b0, 8'h00, 8'h00, 8'h77, 1'b0};
      vecs[7]  = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
      vecs[8]  = '{1'b1, 8'hC7, 8'h5A, 8'hA5, 1'b0};
      vecs[9]  = '{1'b0, 8'hC7, 8'h00, 8'h5A, 1'b0};
      vecs[10] = '{1'b1, 8'hFF, 8'h11, 8'h5A, 1'b1};
      vecs[11] = '{1'b0, 8'h00, 8'h00, 8'h77, 1'b0};
      vecs[12] = '{1'b1, 8'h05, 8'hC3, 8'h77, 1'b0};
      vecs[13] = '{1'b1, 8'h06, 8'h3D, 8'h77, 1'b0};

      rst = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wd0 = 8'h00;
      req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wd1 = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset then idle
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_outputs", {20'd0, rd0, 1'b0, ack0, err0, busy0}, 32'd0);
      end
      check("idle_outputs_w0", {20'd0, rd1, 1'b0, ack1, err1, busy1}, 32'd0);

      // Table: stores, loads, range boundary 199/200/255, RAM untouched by bad stores
      for (int i = 0; i < 14; i++) begin
         txn0(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_err, 1'b0);
      end

      // Inputs changing while busy: still a load of 0x05, and 0x06 is not written
      txn0(1'b0, 8'h05, 8'h00, 8'hC3, 1'b0, 1'b1);
      txn0(1'b0, 8'h06, 8'h00, 8'h3D, 1'b0, 1'b0);

      // Reset while in WAIT
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wd0 = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      check("busy_in_wait", 32'(busy0), 32'd1);
      req0 = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("after_mid_reset", {20'd0, rd0, 1'b0, ack0, err0, busy0}, 32'd0);
      ack_any = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ack0 !== 1'b0) ack_any = 1'b1;
      end
      check("no_ack_after_reset", 32'(ack_any), 32'd0);
      txn0(1'b0, 8'h20, 8'h00, 8'h00, 1'b0, 1'b0);

      // Reset landing exactly on the would-be Ack edge of a store
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wd0 = 8'hFF;
      @(posedge clk);
      repeat (3) @(negedge clk);
      req0 = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("no_ack_reset_on_ack_edge", {30'd0, ack0, busy0}, 32'd0);
      ack_any = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ack0 !== 1'b0) ack_any = 1'b1;
      end
      check("no_late_ack", 32'(ack_any), 32'd0);
      txn0(1'b0, 8'h20, 8'h00, 8'h00, 1'b0, 1'b0);

      // Zero wait states, Req held high across a store and a load
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'h01; wd1 = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      check("w0_c1_ack_busy", {30'd0, ack1, busy1}, 32'd1);
      @(negedge clk);
      check("w0_c2_store_ack", {29'd0, ack1, err1, busy1}, 32'd5);
      we1 = 1'b0; wd1 = 8'h00;
      @(negedge clk);
      check("w0_c3_ack_busy", {30'd0, ack1, busy1}, 32'd1);
      @(negedge clk);
      check("w0_c4_load_ack", {29'd0, ack1, err1, busy1}, 32'd5);
      check("w0_raw_rdata", 32'(rd1), 32'h3C);
      req1 = 1'b0;
      @(negedge clk);
      check("w0_idle_after", {30'd0, ack1, busy1}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
